// File: rtl/txuart_pkg.sv
// txuart_pkg: shared UART definitions (state encoding, bit-period
// derivation, FIFO depth). The receiver on the same link imports these too.
package txuart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int DATA_BITS  = 8;

  // Bit period in clock cycles, truncated.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/txuart_if.sv
// txuart_if: byte write handshake between game logic and the transmitter.
interface txuart_if;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_busy;

  modport master (output i_wr, i_data, input o_ready, o_busy);
  modport slave  (input i_wr, i_data, output o_ready, o_busy);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous FIFO. Head is visible combinationally on
// dout; a push while full is taken only when a pop frees the slot in the
// same cycle. Pointers wrap modulo DEPTH.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/txuart.sv
// txuart: UART transmitter, 8N1 (or 8E1 with if_parity=1), LSB first.
// Optional macro TXUART_FIFO_EN puts a 4-entry FIFO in front of the FSM;
// without it the shift register is the only holding register.
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (only when if_parity=1)
// STOP   | stop bit (high); may chain straight into START
module txuart
  import txuart_pkg::*;
#(
  parameter int clkFreq   = 25000000,
  parameter int baudRate  = 115200,
  parameter bit if_parity = 1'b0
) (
  input  logic     clk,
  input  logic     rstn,
  txuart_if.slave  bus,
  output logic     o_uart_tx
);
  localparam int CPB   = clks_per_bit(clkFreq, baudRate);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  uart_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             par, par_n;
  logic             tx_n;

  logic             bit_end, can_start, avail, load, wr_acc;
  logic [7:0]       next_byte;

  assign bit_end   = (cnt == CNT_W'(CPB - 1));
  // A new frame may begin from IDLE, or on the last cycle of a stop bit.
  assign can_start = (state == IDLE) || ((state == STOP) && bit_end);
  assign load      = can_start & avail;

`ifdef TXUART_FIFO_EN
  logic       fifo_empty, fifo_full, push, pop;
  logic [7:0] fifo_head;

  // pop depends only on FSM state so ready can include it without a loop.
  assign pop         = can_start & ~fifo_empty;
  assign bus.o_ready = ~fifo_full | pop;
  assign wr_acc      = bus.i_wr & bus.o_ready;
  assign avail       = ~fifo_empty | wr_acc;
  // Empty FIFO: the incoming byte bypasses storage and goes straight out.
  assign next_byte   = fifo_empty ? bus.i_data : fifo_head;
  assign push        = wr_acc & ~(load & fifo_empty);
  assign bus.o_busy  = (state != IDLE) | ~fifo_empty;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (bus.i_data),
    .pop   (pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
`else
  assign bus.o_ready = (state == IDLE);
  assign wr_acc      = bus.i_wr & bus.o_ready;
  assign avail       = wr_acc;
  assign next_byte   = bus.i_data;
  assign bus.o_busy  = (state != IDLE);
`endif

  // Next-state, bit timing and next line value.
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (load) begin
          state_n = START;
          shift_n = next_byte;
          par_n   = ^next_byte;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) state_n = if_parity ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (load) begin
            state_n = START;
            shift_n = next_byte;
            par_n   = ^next_byte;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Line is registered from the next state so it changes with the state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  // State, counters and the registered TX line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      par       <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      par       <= par_n;
      o_uart_tx <= tx_n;
    end
  end

endmodule

// File: tb/tb_txuart.sv
// tb_txuart: directed bench for txuart. Two instances share clock and reset:
// u_dut without parity, u_par with even parity. FIFO scenarios are built
// when TXUART_FIFO_EN is defined.
module tb_txuart;
  localparam int CPB = 217;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic tx0, tx1;
  int   errors = 0;
  int   checks = 0;

  txuart_if bus0 ();
  txuart_if bus1 ();

  txuart #(.clkFreq(25000000), .baudRate(115200), .if_parity(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus0), .o_uart_tx(tx0));
  txuart #(.clkFreq(25000000), .baudRate(115200), .if_parity(1'b1)) u_par (
    .clk(clk), .rstn(rstn), .bus(bus1), .o_uart_tx(tx1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic write_byte(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin bus1.i_wr = 1'b1; bus1.i_data = d; end
    else     begin bus0.i_wr = 1'b1; bus0.i_data = d; end
    @(posedge clk); #1;
    bus0.i_wr = 1'b0;
    bus1.i_wr = 1'b0;
  endtask

  // Starts 1 time unit after the edge that began the start bit.
  task automatic expect_frame(input bit sel, input logic [7:0] d, input string tag,
                              output logic busy_last);
    logic [10:0] bits;
    int n, bad;
    n    = sel ? 11 : 10;
    bits = sel ? {1'b1, ^d, d, 1'b0} : {1'b1, 1'b1, d, 1'b0};
    busy_last = 1'b0;
    for (int b = 0; b < n; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if ((sel ? tx1 : tx0) !== bits[b]) bad++;
        if (b == n - 1 && c == CPB - 1) busy_last = sel ? bus1.o_busy : bus0.o_busy;
        @(posedge clk); #1;
      end
      check($sformatf("%s byte %02h bit%0d bad cycles", tag, d, b), bad, 0);
    end
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      if (tx0 !== 1'b1 || bus0.o_busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bl;
    bus0.i_wr = 1'b0; bus0.i_data = 8'h00;
    bus1.i_wr = 1'b0; bus1.i_data = 8'h00;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", int'(tx0), 1);
    check("reset busy", int'(bus0.o_busy), 0);
    check("reset ready", int'(bus0.o_ready), 1);
    check("reset par tx", int'(tx1), 1);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // 1: 0x55 without parity
    write_byte(1'b0, 8'h55);
    check("t1 busy after accept", int'(bus0.o_busy), 1);
    expect_frame(1'b0, 8'h55, "t1", bl);
    check("t1 busy in last stop cycle", int'(bl), 1);
    check("t1 busy after frame", int'(bus0.o_busy), 0);
    check("t1 ready after frame", int'(bus0.o_ready), 1);

    // 2: even parity, 0x07 -> parity 1, 0x03 -> parity 0
    write_byte(1'b1, 8'h07);
    expect_frame(1'b1, 8'h07, "t2", bl);
    check("t2 busy in last stop cycle", int'(bl), 1);
    check("t2 busy after frame", int'(bus1.o_busy), 0);
    write_byte(1'b1, 8'h03);
    expect_frame(1'b1, 8'h03, "t2", bl);
    check("t2 par line idle", int'(tx1), 1);

`ifndef TXUART_FIFO_EN
    // 3: write while busy is dropped
    write_byte(1'b0, 8'hA5);
    fork
      expect_frame(1'b0, 8'hA5, "t3", bl);
      begin
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("t3 ready while busy", int'(bus0.o_ready), 0);
        bus0.i_wr = 1'b1; bus0.i_data = 8'h3C;
        @(posedge clk); #1;
        bus0.i_wr = 1'b0;
      end
    join
    check("t3 busy after frame", int'(bus0.o_busy), 0);
    expect_idle("t3 line idle after dropped write", 3 * CPB);
`else
    // 4: six consecutive writes, sixth dropped, five back-to-back frames
    write_byte(1'b0, 8'h01);
    fork
      begin
        for (int k = 2; k <= 6; k++) begin
          @(negedge clk);
          bus0.i_wr = 1'b1; bus0.i_data = 8'(k);
          #1;
          check($sformatf("t4 ready on write %0d", k), int'(bus0.o_ready), (k < 6) ? 1 : 0);
          @(posedge clk);
        end
        #1 bus0.i_wr = 1'b0;
      end
      begin
        for (int k = 1; k <= 5; k++) expect_frame(1'b0, 8'(k), "t4", bl);
      end
    join
    check("t4 busy after frames", int'(bus0.o_busy), 0);
    expect_idle("t4 no sixth frame", 3 * CPB);

    // 5: write on the exact pop cycle while full
    write_byte(1'b0, 8'h11);
    fork
      begin
        for (int k = 2; k <= 5; k++) begin
          @(negedge clk);
          bus0.i_wr = 1'b1; bus0.i_data = 8'(8'h10 + k);
          @(posedge clk);
        end
        #1 bus0.i_wr = 1'b0;
        repeat (2164) @(posedge clk);
        @(negedge clk);
        check("t5 ready while full", int'(bus0.o_ready), 0);
        @(posedge clk);
        @(negedge clk);
        bus0.i_wr = 1'b1; bus0.i_data = 8'h16;
        #1;
        check("t5 ready on pop cycle", int'(bus0.o_ready), 1);
        @(posedge clk); #1;
        bus0.i_wr = 1'b0;
      end
      begin
        for (int k = 1; k <= 6; k++) expect_frame(1'b0, 8'(8'h10 + k), "t5", bl);
      end
    join
    check("t5 busy after frames", int'(bus0.o_busy), 0);
`endif

    // 6: asynchronous reset in the middle of data bit 3 (0xF0: bit3 = 0)
    write_byte(1'b0, 8'hF0);
    repeat (4 * CPB + 108) @(posedge clk);
    #1;
    check("t6 line in data bit3", int'(tx0), 0);
    #2 rstn = 1'b0;
    #1;
    check("t6 line during reset", int'(tx0), 1);
    check("t6 busy during reset", int'(bus0.o_busy), 0);
    check("t6 ready during reset", int'(bus0.o_ready), 1);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    expect_idle("t6 no remnant frame", 3 * CPB);
    check("t6 ready after release", int'(bus0.o_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
